// File: rtl/buart_pkg.sv
// buart_pkg: FSM encoding and frame constants shared by buart_fifo.
// Define BUART_PARITY_EN to add an even-parity bit to every frame.
package buart_pkg;

    localparam int MIN_DIV   = 4;
    localparam int DATA_BITS = 8;

`ifdef BUART_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;
    localparam state_t AFTER_DATA = S_PARITY;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP
    } state_t;
    localparam state_t AFTER_DATA = S_STOP;
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word fall-through read data.
// Push on a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr];

    // Storage write; no reset needed since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/buart_fifo.sv
// buart_fifo: UART with programmable divider, TX/RX FIFOs and error flags.
// Define BUART_PARITY_EN for 8E1 frames; otherwise frames are 8N1.
module buart_fifo
    import buart_pkg::*;
#(
    parameter int CLK_DIV = 217,
    parameter int DIV_W   = 16,
    parameter int FIFO_AW = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             rx,
    output logic             tx,
    input  logic             wr,
    input  logic [7:0]       tx_data,
    input  logic             rd,
    output logic [7:0]       rx_data,
    output logic             valid,
    output logic             tx_full,
    output logic             busy,
    input  logic             div_we,
    input  logic [DIV_W-1:0] div_di,
    output logic [DIV_W-1:0] div_do,
    input  logic             err_clr,
    output logic             frame_err,
    output logic             overrun
);

    localparam int BIT_W = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_BITS);

    logic [DIV_W-1:0] div;
    logic [1:0]       rx_sync;
    logic             rx_s;
    logic             rx_prev;

    state_t           rx_state;
    state_t           rx_next;
    logic [DIV_W-1:0] rx_cnt;
    logic [DIV_W-1:0] rx_div;
    logic [DIV_W-1:0] rx_lim;
    logic [BIT_W-1:0] rx_bit;
    logic [7:0]       rx_sh;
    logic             rx_tick;
    logic             rx_pbad;
    logic             rx_push;
    logic             rx_full;
    logic             rx_empty;
    logic [FIFO_AW:0] rx_count;
    logic             fe_set;
    logic             ovr_set;

    state_t           tx_state;
    state_t           tx_next;
    logic [DIV_W-1:0] tx_cnt;
    logic [DIV_W-1:0] tx_div;
    logic [BIT_W-1:0] tx_bit;
    logic [7:0]       tx_sh;
    logic [7:0]       tx_head;
    logic             tx_tick;
    logic             tx_pop;
    logic             tx_empty;
    logic [FIFO_AW:0] tx_count;
`ifdef BUART_PARITY_EN
    logic             tx_par;
`endif

    logic             unused_cnt;
    assign unused_cnt = ^{rx_count, tx_count};

    // Divider register, clamped so every bit spans at least MIN_DIV clocks.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            div <= DIV_W'(CLK_DIV);
        else if (div_we)
            div <= (div_di < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_di;
    end
    assign div_do = div;

    // Two-flop synchroniser plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_sync[1];
        end
    end
    assign rx_s = rx_sync[1];

    assign rx_lim  = (rx_state == S_START) ? (rx_div >> 1) : rx_div;
    assign rx_tick = (rx_state != S_IDLE) && (rx_cnt == rx_lim - DIV_W'(1));

    // RX state register with bit timer, bit index and shift register.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DIV_W'(CLK_DIV);
            rx_bit   <= '0;
            rx_sh    <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= (rx_tick || rx_state == S_IDLE) ? '0 : rx_cnt + DIV_W'(1);
            if (rx_state == S_IDLE) begin
                rx_div <= div;
                rx_bit <= '0;
            end else if (rx_tick) begin
                rx_bit <= rx_bit + BIT_W'(1);
            end
            if (rx_tick && rx_state == S_DATA)
                rx_sh <= {rx_s, rx_sh[7:1]};
        end
    end

`ifdef BUART_PARITY_EN
    // Received parity must equal the even parity of the data byte.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            rx_pbad <= 1'b0;
        else if (rx_state == S_IDLE)
            rx_pbad <= 1'b0;
        else if (rx_tick && rx_state == S_PARITY)
            rx_pbad <= rx_s ^ (^rx_sh);
    end
`else
    assign rx_pbad = 1'b0;
`endif

    // RX next-state: a start that reads high at mid-bit is a glitch.
    always_comb begin
        rx_next = rx_state;
        unique case (rx_state)
            S_IDLE:   if (rx_prev && !rx_s) rx_next = S_START;
            S_START:  if (rx_tick) rx_next = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (rx_tick && rx_bit == LAST_DATA) rx_next = AFTER_DATA;
`ifdef BUART_PARITY_EN
            S_PARITY: if (rx_tick) rx_next = S_STOP;
`endif
            S_STOP:   if (rx_tick) rx_next = S_IDLE;
            default:  rx_next = S_IDLE;
        endcase
    end

    // RX outputs: decide at the stop sample whether to push or flag.
    always_comb begin
        rx_push = 1'b0;
        fe_set  = 1'b0;
        ovr_set = 1'b0;
        if (rx_state == S_STOP && rx_tick) begin
            if (!rx_s || rx_pbad)
                fe_set = 1'b1;
            else if (rx_full && !rd)
                ovr_set = 1'b1;
            else
                rx_push = 1'b1;
        end
    end

    // Sticky error flags; a clear beats a same-cycle set.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else if (err_clr) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fe_set)  frame_err <= 1'b1;
            if (ovr_set) overrun   <= 1'b1;
        end
    end

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_rx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (rx_push),
        .din    (rx_sh),
        .pop    (rd),
        .dout   (rx_data),
        .full   (rx_full),
        .empty  (rx_empty),
        .count  (rx_count)
    );
    assign valid = !rx_empty;

    sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_tx_fifo (
        .clk    (clk),
        .resetq (resetq),
        .push   (wr),
        .din    (tx_data),
        .pop    (tx_pop),
        .dout   (tx_head),
        .full   (tx_full),
        .empty  (tx_empty),
        .count  (tx_count)
    );

    assign tx_tick = (tx_state != S_IDLE) && (tx_cnt == tx_div - DIV_W'(1));

    // TX state register; a pop loads the next byte and its divider.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DIV_W'(CLK_DIV);
            tx_bit   <= '0;
            tx_sh    <= '0;
`ifdef BUART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= (tx_tick || tx_state == S_IDLE) ? '0 : tx_cnt + DIV_W'(1);
            if (tx_pop) begin
                tx_sh  <= tx_head;
                tx_div <= div;
                tx_bit <= '0;
`ifdef BUART_PARITY_EN
                tx_par <= ^tx_head;
`endif
            end else if (tx_tick) begin
                tx_bit <= tx_bit + BIT_W'(1);
                if (tx_state == S_DATA) tx_sh <= tx_sh >> 1;
            end
        end
    end

    // TX next-state: chain straight into the next start when data waits.
    always_comb begin
        tx_next = tx_state;
        unique case (tx_state)
            S_IDLE:   if (!tx_empty) tx_next = S_START;
            S_START:  if (tx_tick) tx_next = S_DATA;
            S_DATA:   if (tx_tick && tx_bit == LAST_DATA) tx_next = AFTER_DATA;
`ifdef BUART_PARITY_EN
            S_PARITY: if (tx_tick) tx_next = S_STOP;
`endif
            S_STOP:   if (tx_tick) tx_next = tx_empty ? S_IDLE : S_START;
            default:  tx_next = S_IDLE;
        endcase
    end

    // TX outputs: line level per state and FIFO pop at frame boundaries.
    always_comb begin
        tx     = 1'b1;
        tx_pop = 1'b0;
        unique case (tx_state)
            S_IDLE:   tx_pop = !tx_empty;
            S_START:  tx = 1'b0;
            S_DATA:   tx = tx_sh[0];
`ifdef BUART_PARITY_EN
            S_PARITY: tx = tx_par;
`endif
            S_STOP:   tx_pop = tx_tick && !tx_empty;
            default:  tx = 1'b1;
        endcase
    end

    assign busy = !tx_empty || (tx_state != S_IDLE);

endmodule

// File: tb/tb_buart_fifo.sv
// tb_buart_fifo: directed/random checks of buart_fifo against a queue model.
// Honours BUART_PARITY_EN for the frame length and parity bit.
module tb_buart_fifo;

    localparam int DIV_W = 16;
    localparam int DEPTH = 16;
`ifdef BUART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic             clk = 1'b0;
    logic             resetq = 1'b0;
    logic             rx = 1'b1;
    logic             tx;
    logic             wr = 1'b0;
    logic [7:0]       tx_data = '0;
    logic             rd = 1'b0;
    logic [7:0]       rx_data;
    logic             valid;
    logic             tx_full;
    logic             busy;
    logic             div_we = 1'b0;
    logic [DIV_W-1:0] div_di = '0;
    logic [DIV_W-1:0] div_do;
    logic             err_clr = 1'b0;
    logic             frame_err;
    logic             overrun;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] tx_q[$];
    logic       exp_fe = 1'b0;
    logic       exp_ovr = 1'b0;

    buart_fifo #(.CLK_DIV(217), .DIV_W(DIV_W), .FIFO_AW(4)) dut (
        .clk       (clk),
        .resetq    (resetq),
        .rx        (rx),
        .tx        (tx),
        .wr        (wr),
        .tx_data   (tx_data),
        .rd        (rd),
        .rx_data   (rx_data),
        .valid     (valid),
        .tx_full   (tx_full),
        .busy      (busy),
        .div_we    (div_we),
        .div_di    (div_di),
        .div_do    (div_do),
        .err_clr   (err_clr),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] got, logic [31:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_div(logic [DIV_W-1:0] d);
        div_di = d;
        div_we = 1'b1;
        @(negedge clk);
        div_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_rx(logic [7:0] b, int div, logic stop);
        logic [NBITS-1:0] fr;
        fr = '0;
        fr[8:1] = b;
`ifdef BUART_PARITY_EN
        fr[9] = ^b;
`endif
        fr[NBITS-1] = stop;
        for (int i = 0; i < NBITS; i++) begin
            rx = fr[i];
            repeat (div) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
        if (!stop)
            exp_fe = 1'b1;
        else if (exp_q.size() < DEPTH)
            exp_q.push_back(b);
        else
            exp_ovr = 1'b1;
    endtask

    task automatic check_rx(string tag);
        check({tag, "_valid"}, valid, exp_q.size() != 0);
        if (exp_q.size() != 0)
            check({tag, "_data"}, rx_data, exp_q[0]);
        check({tag, "_ferr"}, frame_err, exp_fe);
        check({tag, "_ovr"}, overrun, exp_ovr);
    endtask

    task automatic do_rd();
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
    endtask

    task automatic do_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_fe = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic wr_byte(logic [7:0] b);
        tx_data = b;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic tx_expect(int div, int nfr);
        logic bits[$];
        int   total;
        int   t;
        foreach (tx_q[f]) begin
            bits.push_back(1'b0);
            for (int i = 0; i < 8; i++) bits.push_back(tx_q[f][i]);
`ifdef BUART_PARITY_EN
            bits.push_back(^tx_q[f]);
`endif
            bits.push_back(1'b1);
        end
        total = nfr * NBITS * div;
        t = 0;
        while (tx !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("tx_start_seen", tx, 1'b0);
        if (tx !== 1'b0) return;
        for (int c = 0; c <= total; c++) begin
            if (c < total)
                check("tx_line", tx, bits[c / div]);
            if (c == total - 1)
                check("tx_busy_last", busy, 1'b1);
            if (c == total) begin
                check("tx_busy_end", busy, 1'b0);
                check("tx_idle_end", tx, 1'b1);
            end
            if (c < total) @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);

        check("rst_tx", tx, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_txfull", tx_full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_div", div_do, 217);
        check("rst_rxdata", rx_data, 8'h00);

        tx_q = {8'h55};
        fork
            tx_expect(217, 1);
            wr_byte(8'h55);
        join

        set_div(2);
        check("div_clamp", div_do, 4);
        set_div(20);
        check("div_20", div_do, 20);

        send_rx(8'hA3, 20, 1'b1);
        check_rx("rx_a3");
        do_rd();
        check_rx("rx_a3_rd");

        for (int i = 0; i < DEPTH; i++)
            send_rx(8'($urandom), 20, 1'b1);
        check_rx("rx_full16");
        send_rx(8'($urandom), 20, 1'b1);
        check_rx("rx_ovr");
        for (int i = 0; i < DEPTH; i++) begin
            check("rx_drain", rx_data, exp_q[0]);
            do_rd();
        end
        check_rx("rx_drained");
        do_clr();
        check_rx("rx_ovr_clr");

        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (60) @(negedge clk);
        check_rx("glitch");
        send_rx(8'($urandom), 20, 1'b1);
        check_rx("after_glitch");
        do_rd();

        send_rx(8'h3C, 20, 1'b0);
        check_rx("stop0");
        do_clr();
        check_rx("stop0_clr");

        set_div(4);
        tx_q = {};
        for (int i = 0; i < 3; i++) tx_q.push_back(8'($urandom));
        fork
            tx_expect(4, 3);
            begin
                for (int i = 0; i < 3; i++) wr_byte(tx_q[i]);
            end
        join

        set_div(217);
        wr_byte(8'hF0);
        repeat (20) @(negedge clk);
        resetq = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        @(negedge clk);
        resetq = 1'b1;
        @(negedge clk);
        check("midrst_div", div_do, 217);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
